// File: rtl/holy_core_pkg.sv
// Shared types and constants for the AXI-Lite responder: FSM states, response codes, register indices.
package holy_core_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = 4;
  localparam int unsigned REG_IDX_W  = 4;

  typedef enum logic { W_IDLE, W_RESP } axi_wr_state_t;
  typedef enum logic { R_IDLE, R_DATA } axi_rd_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [REG_IDX_W-1:0] REG_IDX_COUNTER = 4'd14;
  localparam logic [REG_IDX_W-1:0] REG_IDX_ID      = 4'd15;

  // True when the word index addresses one of the read/write registers.
  function automatic logic idx_is_rw(input logic [REG_IDX_W-1:0] idx, input int unsigned num_regs);
    return 32'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/holy_axi_lite_responder.sv
// AXI-Lite responder: NUM_REGS byte-strobed RW registers, a free-running cycle counter and an ID word.
// Independent read and write FSMs, one outstanding transaction each.
module holy_axi_lite_responder
  import holy_core_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'h484F4C59
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXI_STRB_W-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [AXI_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [NUM_REGS*32-1:0]  reg_out
);

  axi_wr_state_t          wr_state_q, wr_state_d;
  axi_rd_state_t          rd_state_q, rd_state_d;
  logic                   aw_held_q, aw_held_d;
  logic [REG_IDX_W-1:0]   aw_idx_q, aw_idx_d;
  logic                   w_held_q, w_held_d;
  logic [AXI_DATA_W-1:0]  wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0]  wstrb_q, wstrb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   rvalid_q, rvalid_d;
  logic [AXI_DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [AXI_DATA_W-1:0]  cnt_q;
  logic [AXI_DATA_W-1:0]  regs_q [NUM_REGS];
  logic [AXI_DATA_W-1:0]  regs_d [NUM_REGS];
  logic                   aw_hs, w_hs;
  logic [REG_IDX_W-1:0]   ar_idx;
  logic                   unused_addr_bits;

  assign s_axi_awready = (wr_state_q == W_IDLE) && !aw_held_q;
  assign s_axi_wready  = (wr_state_q == W_IDLE) && !w_held_q;
  assign s_axi_arready = (rd_state_q == R_IDLE);
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_idx = s_axi_araddr[5:2];

  assign unused_addr_bits = ^{s_axi_awaddr[31:6], s_axi_awaddr[1:0],
                              s_axi_araddr[31:6], s_axi_araddr[1:0]};

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) reg_out[32*k +: 32] = regs_q[k];
  end

  // Write FSM: a handshake this cycle counts as held, so the commit happens at the later handshake edge.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[5:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (aw_idx_d == REG_IDX_W'(k)) begin
              for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wstrb_d[b]) regs_d[k][8*b +: 8] = wdata_d[8*b +: 8];
              end
            end
          end
          bresp_d    = idx_is_rw(aw_idx_d, NUM_REGS) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM: the register value is sampled at the AR handshake edge.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rdata_d = '0;
          rresp_d = AXI_RESP_OKAY;
          if (idx_is_rw(ar_idx, NUM_REGS)) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (ar_idx == REG_IDX_W'(k)) rdata_d = regs_q[k];
            end
          end else if (ar_idx == REG_IDX_COUNTER) begin
            rdata_d = cnt_q;
          end else if (ar_idx == REG_IDX_ID) begin
            rdata_d = ID_VALUE;
          end else begin
            rresp_d = AXI_RESP_SLVERR;
          end
          rvalid_d   = 1'b1;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      cnt_q      <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      cnt_q      <= cnt_q + 32'd1;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
    end
  end

endmodule

// File: tb/tb_holy_axi_lite_responder.sv
// Self-checking bench for holy_axi_lite_responder: directed map/latency/reset steps plus randomized traffic vs a register-map model.
module tb_holy_axi_lite_responder;
  import holy_core_pkg::*;

  localparam int unsigned NUM_REGS = 8;
  localparam logic [31:0] ID_WORD  = 32'h484F4C59;

  logic                   clk, rst_n;
  logic [31:0]            awaddr, wdata, araddr, rdata;
  logic [3:0]             wstrb;
  logic                   awvalid, awready, wvalid, wready, bvalid, bready;
  logic                   arvalid, arready, rvalid, rready;
  logic [1:0]             bresp, rresp;
  logic [NUM_REGS*32-1:0] reg_out;

  holy_axi_lite_responder #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_WORD)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time base: clock edges seen since reset was released.
  int unsigned tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  logic [31:0] m_regs [NUM_REGS];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s, output logic [1:0] exp_resp);
    if (idx < NUM_REGS) begin
      m_regs[idx] = merge(m_regs[idx], d, s);
      exp_resp = 2'b00;
    end else begin
      exp_resp = 2'b10;
    end
  endtask

  task automatic model_read(input int idx, input int unsigned cyc, output logic [31:0] d, output logic [1:0] r);
    r = 2'b00;
    if (idx < NUM_REGS) d = m_regs[idx];
    else if (idx == 14) d = 32'(cyc);
    else if (idx == 15) d = ID_WORD;
    else begin d = 32'h0; r = 2'b10; end
  endtask

  task automatic check_reg_out;
    for (int k = 0; k < NUM_REGS; k++) check($sformatf("reg_out[%0d]", k), reg_out[32*k +: 32], m_regs[k]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold, output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int n;
    aw_done = 0; w_done = 0;
    for (int cyc = 0; cyc < 60 && !(aw_done && w_done); cyc++) begin
      awaddr  = addr; wdata = d; wstrb = s;
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin tick; n++; end
    check("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    for (int h = 0; h < b_hold; h++) begin
      tick;
      check("bvalid_hold", {bvalid, awready, wready}, 3'b100);
      check("bresp_hold", bresp, resp);
    end
    bready = 1; tick; bready = 0;
    check("bvalid_clear", bvalid, 1'b0);
    check("wr_ready_back", {awready, wready}, 2'b11);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold,
                          output logic [31:0] d, output logic [1:0] r, output int unsigned cyc_hs);
    int n;
    araddr = addr; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin tick; n++; end
    check("arready_seen", arready, 1'b1);
    cyc_hs = tb_cyc;
    tick;
    arvalid = 0;
    check("rvalid_latency", rvalid, 1'b1);
    d = rdata; r = rresp;
    for (int h = 0; h < r_hold; h++) begin
      tick;
      check("rdata_stable", {rvalid, arready, rdata, rresp}, {1'b1, 1'b0, d, r});
    end
    rready = 1; tick; rready = 0;
    check("rvalid_clear", rvalid, 1'b0);
  endtask

  task automatic read_check(input string tag, input int idx, input int r_hold);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    int unsigned c;
    axi_read(32'(idx * 4), r_hold, d, r, c);
    model_read(idx, c, ed, er);
    check({tag, "_rdata"}, d, ed);
    check({tag, "_rresp"}, r, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] d1, d2;
    logic [1:0]  r1, r2;
    int unsigned c1, c2;
    int idx, op;
    logic [31:0] rd;
    logic [3:0]  rs;

    rst_n = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 32'h0;
    repeat (3) tick;
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_rdata", rdata, 32'h0);
    check("rst_resps", {bresp, rresp}, 4'h0);
    check("rst_reg_out", reg_out, {NUM_REGS*32{1'b0}} );
    rst_n = 1;
    tick;
    check("idle_readies", {awready, wready, arready}, 3'b111);

    // Full-word write then read back.
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp);
    check("w04_bresp", resp, 2'b00);
    m_regs[1] = 32'hDEADBEEF;
    read_check("r04", 1, 0);
    check("reg_out1", reg_out[63:32], 32'hDEADBEEF);

    // Byte strobes.
    axi_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp);
    axi_write(32'h00, 32'h11223344, 4'b0101, 0, 0, 0, resp);
    check("strb_reg0", reg_out[31:0], 32'hFF22FF44);
    m_regs[0] = 32'hFF22FF44;

    // W two cycles ahead of AW, bready held off for 3 cycles.
    axi_write(32'h0C, 32'hA5A5_0F0F, 4'hF, 2, 0, 3, resp);
    check("wfirst_bresp", resp, 2'b00);
    m_regs[3] = 32'hA5A5_0F0F;

    // Fixed map entries and unmapped index.
    read_check("id", 15, 1);
    axi_read(32'h3C, 0, d1, r1, c1);
    check("id_const", {d1, r1}, {ID_WORD, 2'b00});
    axi_read(32'h30, 0, d1, r1, c1);
    check("unmapped", {d1, r1}, {32'h0, 2'b10});

    // Counter reads 10 cycles apart.
    axi_read(32'h38, 0, d1, r1, c1);
    repeat (8) tick;
    axi_read(32'h38, 0, d2, r2, c2);
    check("cnt_delta", d2 - d1, 32'd10);
    check("cnt_abs", d1, 32'(c1));

    // Writes to the counter and ID are rejected without side effects.
    axi_write(32'h38, 32'h0, 4'hF, 0, 0, 0, resp);
    check("w38_slverr", resp, 2'b10);
    read_check("cnt_after_w", 14, 0);
    axi_write(32'h3C, 32'h0, 4'hF, 1, 0, 0, resp);
    check("w3c_slverr", resp, 2'b10);

    // Zero strobe to an RW register.
    axi_write(32'h04, 32'h12345678, 4'h0, 0, 1, 0, resp);
    check("strb0_bresp", resp, 2'b00);
    check("strb0_nochange", reg_out[63:32], 32'hDEADBEEF);

    // Read and write to the same register in one cycle: read sees the old value.
    axi_write(32'h08, 32'd5, 4'hF, 0, 0, 0, resp);
    m_regs[2] = 32'd5;
    araddr = 32'h08; arvalid = 1; rready = 0;
    awaddr = 32'h08; awvalid = 1; wdata = 32'd9; wstrb = 4'hF; wvalid = 1; bready = 0;
    check("same_readies", {awready, wready, arready}, 3'b111);
    tick;
    arvalid = 0; awvalid = 0; wvalid = 0;
    check("same_rvalid_bvalid", {rvalid, bvalid}, 2'b11);
    check("same_rdata_old", rdata, 32'd5);
    check("same_bresp", {bresp, rresp}, 4'h0);
    check("same_reg_new", reg_out[95:64], 32'd9);
    rready = 1; bready = 1; tick; rready = 0; bready = 0;
    check("same_clear", {rvalid, bvalid}, 2'b00);
    m_regs[2] = 32'd9;
    read_check("same_after", 2, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      op  = $urandom_range(0, 1);
      idx = $urandom_range(0, 15);
      if (op == 0) begin
        rd = $urandom;
        rs = 4'($urandom_range(0, 15));
        axi_write(32'(idx * 4) | 32'($urandom_range(0, 3)) | (32'($urandom) << 6), rd, rs,
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), resp);
        model_write(idx, rd, rs, eresp);
        check("rand_bresp", resp, eresp);
      end else begin
        read_check("rand_rd", idx, $urandom_range(0, 2));
      end
    end
    check_reg_out();

    // Reset in the middle of a pending read and write response.
    awaddr = 32'h10; awvalid = 1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1; bready = 0;
    araddr = 32'h10; arvalid = 1; rready = 0;
    tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("pre_rst_valids", {rvalid, bvalid}, 2'b11);
    #2 rst_n = 0;
    #1;
    check("mid_rst_valids", {rvalid, bvalid}, 2'b00);
    check("mid_rst_regs", reg_out, {NUM_REGS*32{1'b0}});
    for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 32'h0;
    repeat (2) tick;
    rst_n = 1;
    check("post_rst_readies", {awready, wready, arready}, 3'b111);
    axi_read(32'h38, 0, d1, r1, c1);
    check("cnt_restart", {d1, r1}, {32'h0, 2'b00});
    read_check("post_rst_cnt", 14, 0);
    read_check("post_rst_reg4", 4, 0);
    check_reg_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
